// File: rtl/uart_io_bridge_if.sv
// uart_io_bridge_if
// Groups the J1 I/O bus signals that connect the UART debug bridge to the
// top-level arbiter and the board I/O responder.
//   bus_req  master->slave  request ownership of the I/O bus
//   bus_gnt  slave->master  arbiter grant
//   io_rd    master->slave  one-cycle read strobe
//   io_wr    master->slave  one-cycle write strobe
//   io_addr  master->slave  16-bit I/O address
//   io_dout  master->slave  16-bit write data
//   io_din   slave->master  16-bit read data, valid in the io_rd cycle
interface uart_io_bridge_if;
    logic        bus_req;
    logic        bus_gnt;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;

    modport master (
        output bus_req, io_rd, io_wr, io_addr, io_dout,
        input  bus_gnt, io_din
    );

    modport slave (
        input  bus_req, io_rd, io_wr, io_addr, io_dout,
        output bus_gnt, io_din
    );
endinterface

// File: rtl/uart_io_bridge.sv
// uart_io_bridge
// UART debug initiator for the J1 I/O bus. 8N1 command frames are parsed
// into single io_rd / io_wr transactions; a status byte or the read data is
// returned over UART.
//   clk       system clock, posedge
//   reset     synchronous, active-high
//   uart_rxd  UART receive line (asynchronous, idle high)
//   uart_txd  UART transmit line (idle high)
//   busy      high from first command byte until the last reply stop bit ends
//   bus       I/O bus master port (bus_req/bus_gnt, io_rd/io_wr, io_addr,
//             io_dout, io_din)
// Commands (big-endian): 57 AH AL DH DL -> write, reply 4B
//                        52 AH AL       -> read, reply DH DL
//                        anything else  -> reply 3F
module uart_io_bridge #(
    parameter int CLK_HZ      = 24_000_000,
    parameter int BAUD        = 115_200,
    parameter int TIMEOUT_CYC = 2_400_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    output logic                    uart_txd,
    output logic                    busy,
    uart_io_bridge_if.master        bus
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_state_r;
    logic [CW-1:0] rx_cnt_r;
    logic [2:0]    rx_bit_r;
    logic [7:0]    rx_shift_r;
    logic [7:0]    rx_data_r;
    logic          rx_valid_r;
    logic          rxd_meta_r;
    logic          rxd_sync_r;
    logic          rxd_prev_r;

    // Synchronise rxd, detect start edge, sample bits at their centres.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else begin
            rxd_meta_r <= uart_rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
            rx_valid_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= '0;
                    rx_bit_r <= 3'd0;
                    if (rxd_prev_r && !rxd_sync_r) begin
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_state_r <= rxd_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == DIV_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_shift_r <= {rxd_sync_r, rx_shift_r[7:1]};
                        rx_bit_r   <= rx_bit_r + 3'd1;
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 1'b1;
                    end
                end
                RX_STOP: begin
                    // A low stop bit is a framing error: the byte is discarded.
                    if (rx_cnt_r == DIV_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_state_r <= RX_IDLE;
                        if (rxd_sync_r) begin
                            rx_valid_r <= 1'b1;
                            rx_data_r  <= rx_shift_r;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 1'b1;
                    end
                end
                default: rx_state_r <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmitter: one shift register holds a whole one- or two-byte reply,
    // so consecutive reply bytes leave with no idle gap.
    // ------------------------------------------------------------------
    logic          tx_load_r;
    logic [19:0]   tx_frame_r;
    logic [4:0]    tx_nbits_r;
    logic          tx_active_r;
    logic [18:0]   tx_shift_r;
    logic [4:0]    tx_left_r;
    logic [CW-1:0] tx_cnt_r;
    logic          txd_r;
    logic          tx_done_s;

    assign tx_done_s = tx_active_r && (tx_cnt_r == DIV_LAST) && (tx_left_r == 5'd0);

    // Serialise the loaded frame, one bit per DIV cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            txd_r       <= 1'b1;
            tx_active_r <= 1'b0;
            tx_shift_r  <= '1;
            tx_left_r   <= 5'd0;
            tx_cnt_r    <= '0;
        end else if (tx_load_r) begin
            txd_r       <= tx_frame_r[0];
            tx_shift_r  <= tx_frame_r[19:1];
            tx_left_r   <= tx_nbits_r - 5'd1;
            tx_cnt_r    <= '0;
            tx_active_r <= 1'b1;
        end else if (tx_active_r) begin
            if (tx_cnt_r == DIV_LAST) begin
                tx_cnt_r <= '0;
                if (tx_left_r == 5'd0) begin
                    tx_active_r <= 1'b0;
                    txd_r       <= 1'b1;
                end else begin
                    txd_r      <= tx_shift_r[0];
                    tx_shift_r <= {1'b1, tx_shift_r[18:1]};
                    tx_left_r  <= tx_left_r - 5'd1;
                end
            end else begin
                tx_cnt_r <= tx_cnt_r + 1'b1;
            end
        end else begin
            txd_r <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Command parser and bus sequencer
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        P_IDLE, P_GET_AH, P_GET_AL, P_GET_DH, P_GET_DL, P_REQ, P_ACCESS, P_REPLY
    } p_state_t;

    p_state_t      p_state_r;
    logic          is_wr_r;
    logic [7:0]    addr_hi_r;
    logic [7:0]    data_hi_r;
    logic [TW-1:0] to_cnt_r;
    logic          bus_req_r;
    logic          io_rd_r;
    logic          io_wr_r;
    logic [15:0]   io_addr_r;
    logic [15:0]   io_dout_r;
    logic          busy_r;

    // Parse command bytes, run the bus access and hand the reply to TX.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_state_r  <= P_IDLE;
            is_wr_r    <= 1'b0;
            addr_hi_r  <= 8'h00;
            data_hi_r  <= 8'h00;
            to_cnt_r   <= '0;
            bus_req_r  <= 1'b0;
            io_rd_r    <= 1'b0;
            io_wr_r    <= 1'b0;
            io_addr_r  <= 16'h0000;
            io_dout_r  <= 16'h0000;
            busy_r     <= 1'b0;
            tx_load_r  <= 1'b0;
            tx_frame_r <= '1;
            tx_nbits_r <= 5'd0;
        end else begin
            tx_load_r <= 1'b0;
            io_rd_r   <= 1'b0;
            io_wr_r   <= 1'b0;
            case (p_state_r)
                P_IDLE: begin
                    to_cnt_r <= '0;
                    if (rx_valid_r) begin
                        busy_r <= 1'b1;
                        case (rx_data_r)
                            8'h57: begin
                                is_wr_r   <= 1'b1;
                                p_state_r <= P_GET_AH;
                            end
                            8'h52: begin
                                is_wr_r   <= 1'b0;
                                p_state_r <= P_GET_AH;
                            end
                            default: begin
                                tx_frame_r <= {10'h3FF, 1'b1, 8'h3F, 1'b0};
                                tx_nbits_r <= 5'd10;
                                tx_load_r  <= 1'b1;
                                p_state_r  <= P_REPLY;
                            end
                        endcase
                    end
                end
                P_GET_AH, P_GET_AL, P_GET_DH, P_GET_DL: begin
                    if (rx_valid_r) begin
                        to_cnt_r <= '0;
                        case (p_state_r)
                            P_GET_AH: begin
                                addr_hi_r <= rx_data_r;
                                p_state_r <= P_GET_AL;
                            end
                            P_GET_AL: begin
                                if (is_wr_r) begin
                                    io_addr_r[7:0] <= 8'h00;
                                    data_hi_r      <= 8'h00;
                                    p_state_r      <= P_GET_DH;
                                end else begin
                                    p_state_r <= P_REQ;
                                    bus_req_r <= 1'b1;
                                end
                                // Address is latched now so it is stable well before ACCESS.
                                io_addr_r <= {addr_hi_r, rx_data_r};
                            end
                            P_GET_DH: begin
                                data_hi_r <= rx_data_r;
                                p_state_r <= P_GET_DL;
                            end
                            P_GET_DL: begin
                                io_dout_r <= {data_hi_r, rx_data_r};
                                bus_req_r <= 1'b1;
                                p_state_r <= P_REQ;
                            end
                            default: p_state_r <= P_IDLE;
                        endcase
                    end else if (to_cnt_r == TO_LAST) begin
                        // Inter-byte silence: abandon the command without a reply.
                        to_cnt_r  <= '0;
                        busy_r    <= 1'b0;
                        p_state_r <= P_IDLE;
                    end else begin
                        to_cnt_r <= to_cnt_r + 1'b1;
                    end
                end
                P_REQ: begin
                    if (bus.bus_gnt) begin
                        io_wr_r   <= is_wr_r;
                        io_rd_r   <= !is_wr_r;
                        p_state_r <= P_ACCESS;
                    end
                end
                P_ACCESS: begin
                    // io_din is valid during the strobe cycle and is captured here.
                    bus_req_r  <= 1'b0;
                    tx_load_r  <= 1'b1;
                    p_state_r  <= P_REPLY;
                    if (is_wr_r) begin
                        tx_frame_r <= {10'h3FF, 1'b1, 8'h4B, 1'b0};
                        tx_nbits_r <= 5'd10;
                    end else begin
                        tx_frame_r <= {1'b1, bus.io_din[7:0], 1'b0, 1'b1, bus.io_din[15:8], 1'b0};
                        tx_nbits_r <= 5'd20;
                    end
                end
                P_REPLY: begin
                    if (tx_done_s) begin
                        busy_r    <= 1'b0;
                        p_state_r <= P_IDLE;
                    end
                end
                default: p_state_r <= P_IDLE;
            endcase
        end
    end

    assign uart_txd    = txd_r;
    assign busy        = busy_r;
    assign bus.bus_req = bus_req_r;
    assign bus.io_rd   = io_rd_r;
    assign bus.io_wr   = io_wr_r;
    assign bus.io_addr = io_addr_r;
    assign bus.io_dout = io_dout_r;

endmodule
